// File: rtl/mesi_lru_ctrl.sv
// mesi_lru_pkg / mesi_lru_ctrl
//
// Per-access L1 controller sitting between a command source and an 8-way
// cache array. One command is accepted per handshake. The set the array
// returns is resolved into hit/miss and a victim. MESI and LRU updates are
// applied, and the whole updated set goes back to the array with a
// one-cycle write strobe. The block also reports L2 bus intent and keeps
// statistics counters.
//
// Build option:
//   CTRL_STATS_EN - when defined, the read/write/hit/miss counters are
//                   implemented. When undefined, the counter ports are tied
//                   to 0.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   instr_valid/ready command handshake (ready only in IDLE, never in rst)
//   instruction      command_t: opcode n, address tag/set_index/offset
//   array_cmd        captured command; its set_index addresses the array
//                    for both the read and the write-back
//   cache_out        set read by the array (sampled in EVAL)
//   cache_in         updated set to write back
//   wr_en            pulse: write cache_in to array_cmd.address.set_index
//   done             pulse: command complete
//   hit, way, l2_op  result of the last command, valid with done
//   wb_req           pulse with done: the evicted or snooped line was M
//   read_cnt, write_cnt, hit_cnt, miss_cnt  statistics
//
// SETS and WAYS live in mesi_lru_pkg because the port types depend on them.

package mesi_lru_pkg;
    localparam int SETS   = 16384;
    localparam int WAYS   = 8;
    localparam int SET_W  = $clog2(SETS);
    localparam int WAY_W  = $clog2(WAYS);
    localparam int OFF_W  = 6;
    localparam int ADDR_W = 32;
    localparam int TAG_W  = ADDR_W - SET_W - OFF_W;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {MESI_I, MESI_S, MESI_E, MESI_M} mesi_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [SET_W-1:0] set_index;
        logic [OFF_W-1:0] offset;
    } address_t;

    typedef struct packed {
        logic [3:0] n;
        address_t   address;
    } command_t;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        mesi_t             mesi;
        logic [WAY_W-1:0]  lru;
        logic [DATA_W-1:0] data;
    } cache_line_t;
endpackage

module mesi_lru_ctrl
    import mesi_lru_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          instr_valid,
    output logic                          instr_ready,
    input  command_t                      instruction,
    output command_t                      array_cmd,
    input  cache_line_t [WAYS-1:0]        cache_out,
    output cache_line_t [WAYS-1:0]        cache_in,
    output logic                          wr_en,
    output logic                          done,
    output logic                          hit,
    output logic [WAY_W-1:0]              way,
    output logic [1:0]                    l2_op,
    output logic                          wb_req,
    output logic [CNT_W-1:0]              read_cnt,
    output logic [CNT_W-1:0]              write_cnt,
    output logic [CNT_W-1:0]              hit_cnt,
    output logic [CNT_W-1:0]              miss_cnt
);

    localparam logic [1:0] L2_NONE = 2'd0;
    localparam logic [1:0] L2_READ = 2'd1;
    localparam logic [1:0] L2_RFO  = 2'd2;

    typedef enum logic [1:0] {IDLE, LOOKUP, EVAL, COMMIT} state_t;

    state_t                 state_q, state_d;
    logic                   ready_q, ready_d;
    command_t               cmd_q, cmd_d;
    cache_line_t [WAYS-1:0] set_q, set_d;
    logic                   wr_en_q, wr_en_d;
    logic                   done_q, done_d;
    logic                   hit_q, hit_d;
    logic [WAY_W-1:0]       way_q, way_d;
    logic [1:0]             l2_q, l2_d;
    logic                   wb_q, wb_d;

    // Lookup / update results, meaningful while in EVAL
    logic                   hit_v;
    logic [WAY_W-1:0]       hit_way, inv_way, lru_way, sel_way;
    logic                   inv_found;
    logic [WAY_W-1:0]       old_lru;
    logic                   is_access;
    cache_line_t [WAYS-1:0] new_set;
    logic [1:0]             l2_n;
    logic                   wb_n;
    logic                   change;

    logic                   accept;

    assign accept      = (state_q == IDLE) && instr_valid && instr_ready;
    // ready_q is cleared by reset, so ready rises one cycle after rst drops
    assign instr_ready = ready_q & ~rst;

    always_comb begin
        hit_v     = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        lru_way   = '0;
        // Scan downward so the lowest matching index is the one left standing
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (cache_out[i].mesi != MESI_I && cache_out[i].tag == cmd_q.address.tag) begin
                hit_v   = 1'b1;
                hit_way = WAY_W'(i);
            end
            if (cache_out[i].mesi == MESI_I) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(i);
            end
            if (cache_out[i].lru == WAY_W'(WAYS - 1)) begin
                lru_way = WAY_W'(i);
            end
        end

        sel_way   = hit_v ? hit_way : (inv_found ? inv_way : lru_way);
        old_lru   = cache_out[sel_way].lru;
        is_access = (cmd_q.n == 4'd0) || (cmd_q.n == 4'd1) || (cmd_q.n == 4'd2);

        new_set = cache_out;
        l2_n    = L2_NONE;
        wb_n    = 1'b0;

        if (is_access) begin
            // Age every way that was more recent than the touched one,
            // which keeps the LRU field a permutation
            for (int i = 0; i < WAYS; i++) begin
                if (cache_out[i].lru < old_lru) begin
                    new_set[i].lru = cache_out[i].lru + 1'b1;
                end
            end
            new_set[sel_way].lru = '0;

            if (!hit_v) begin
                new_set[sel_way].tag = cmd_q.address.tag;
                wb_n = (cache_out[sel_way].mesi == MESI_M);
            end

            if (cmd_q.n == 4'd1) begin
                new_set[sel_way].mesi = MESI_M;
                if (!hit_v || cache_out[sel_way].mesi == MESI_S) begin
                    l2_n = L2_RFO;
                end
            end else if (!hit_v) begin
                new_set[sel_way].mesi = MESI_E;
                l2_n = L2_READ;
            end
        end else if (cmd_q.n == 4'd3 && hit_v) begin
            new_set[sel_way].mesi = MESI_I;
        end else if (cmd_q.n == 4'd4 && hit_v) begin
            wb_n = (cache_out[sel_way].mesi == MESI_M);
            new_set[sel_way].mesi = MESI_S;
        end

        change = (new_set != cache_out);
    end

    always_comb begin
        state_d = state_q;
        ready_d = ready_q;
        cmd_d   = cmd_q;
        set_d   = set_q;
        wr_en_d = 1'b0;
        done_d  = 1'b0;
        hit_d   = hit_q;
        way_d   = way_q;
        l2_d    = l2_q;
        wb_d    = 1'b0;

        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (accept) begin
                    cmd_d   = instruction;
                    ready_d = 1'b0;
                    if (instruction.n <= 4'd4) begin
                        state_d = LOOKUP;
                    end else begin
                        // Clear/no-op/undefined opcodes skip the array entirely
                        state_d = COMMIT;
                        done_d  = 1'b1;
                        hit_d   = 1'b0;
                        way_d   = '0;
                        l2_d    = L2_NONE;
                    end
                end
            end
            LOOKUP: state_d = EVAL;
            EVAL: begin
                state_d = COMMIT;
                done_d  = 1'b1;
                hit_d   = hit_v;
                way_d   = sel_way;
                l2_d    = l2_n;
                wb_d    = wb_n;
                set_d   = new_set;
                wr_en_d = change;
            end
            COMMIT: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            cmd_q   <= '0;
            set_q   <= '0;
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            hit_q   <= 1'b0;
            way_q   <= '0;
            l2_q    <= L2_NONE;
            wb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            cmd_q   <= cmd_d;
            set_q   <= set_d;
            wr_en_q <= wr_en_d;
            done_q  <= done_d;
            hit_q   <= hit_d;
            way_q   <= way_d;
            l2_q    <= l2_d;
            wb_q    <= wb_d;
        end
    end

    assign array_cmd = cmd_q;
    assign cache_in  = set_q;
    assign wr_en     = wr_en_q;
    assign done      = done_q;
    assign hit       = hit_q;
    assign way       = way_q;
    assign l2_op     = l2_q;
    assign wb_req    = wb_q;

`ifdef CTRL_STATS_EN
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Counters change on the edge into COMMIT so they are current alongside done
    always_comb begin
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (state_q == EVAL) begin
            if (cmd_q.n == 4'd0 || cmd_q.n == 4'd2) rd_cnt_d = sat_inc(rd_cnt_q);
            if (cmd_q.n == 4'd1)                    wr_cnt_d = sat_inc(wr_cnt_q);
            if (is_access) begin
                if (hit_v) hit_cnt_d  = sat_inc(hit_cnt_q);
                else       miss_cnt_d = sat_inc(miss_cnt_q);
            end
        end else if (accept && instruction.n == 4'd8) begin
            rd_cnt_d   = '0;
            wr_cnt_d   = '0;
            hit_cnt_d  = '0;
            miss_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign read_cnt  = rd_cnt_q;
    assign write_cnt = wr_cnt_q;
    assign hit_cnt   = hit_cnt_q;
    assign miss_cnt  = miss_cnt_q;
`else
    assign read_cnt  = '0;
    assign write_cnt = '0;
    assign hit_cnt   = '0;
    assign miss_cnt  = '0;
`endif

endmodule

// File: tb/tb_mesi_lru_ctrl.sv
// Directed bench for mesi_lru_ctrl. A small array model holds set 5 and
// applies write-backs. All expected values are hand-derived constants.
module tb_mesi_lru_ctrl;
    import mesi_lru_pkg::*;

`ifdef CTRL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   instr_valid;
    logic                   instr_ready;
    command_t               instruction;
    command_t               array_cmd;
    cache_line_t [WAYS-1:0] cache_out;
    cache_line_t [WAYS-1:0] cache_in;
    logic                   wr_en, done, hit, wb_req;
    logic [WAY_W-1:0]       way;
    logic [1:0]             l2_op;
    logic [31:0]            read_cnt, write_cnt, hit_cnt, miss_cnt;

    always #5 clk = ~clk;

    mesi_lru_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instruction(instruction), .array_cmd(array_cmd), .cache_out(cache_out),
        .cache_in(cache_in), .wr_en(wr_en), .done(done), .hit(hit), .way(way),
        .l2_op(l2_op), .wb_req(wb_req), .read_cnt(read_cnt), .write_cnt(write_cnt),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    // Array model: only set 5 is populated
    cache_line_t [WAYS-1:0] set5;
    logic                   init_load;
    int                     wr_cnt = 0;

    always @(posedge clk) begin
        if (init_load) begin
            for (int i = 0; i < WAYS; i++) begin
                set5[i].tag  <= '0;
                set5[i].mesi <= MESI_I;
                set5[i].lru  <= 3'(i);
                set5[i].data <= 32'hD000_0000 + 32'(i);
            end
        end else if (wr_en && array_cmd.address.set_index == 14'd5) begin
            set5 <= cache_in;
        end
        if (wr_en) wr_cnt <= wr_cnt + 1;
    end

    always_comb cache_out = (array_cmd.address.set_index == 14'd5) ? set5 : '0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Captured at the done cycle
    int                     lat;
    logic                   r_hit, r_wr, r_wb;
    logic [WAY_W-1:0]       r_way;
    logic [1:0]             r_l2;
    cache_line_t [WAYS-1:0] r_set;

    task automatic issue(input logic [3:0] op, input logic [11:0] tg);
        int guard;
        @(negedge clk);
        instruction.n                 = op;
        instruction.address.tag       = tg;
        instruction.address.set_index = 14'd5;
        instruction.address.offset    = 6'd0;
        instr_valid = 1'b1;
        guard = 0;
        while (!instr_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!instr_ready) check_eq("ready_timeout", 64'd0, 64'd1);
        @(negedge clk);
        instr_valid = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!done) check_eq("done_timeout", 64'd0, 64'd1);
        r_hit = hit;
        r_wr  = wr_en;
        r_wb  = wb_req;
        r_way = way;
        r_l2  = l2_op;
        r_set = cache_in;
    endtask

    task automatic chk_cnt(input string tag, input int rd, input int wr, input int h, input int m);
        check_eq({tag, "_read_cnt"},  64'(read_cnt),  STATS ? 64'(rd) : 64'd0);
        check_eq({tag, "_write_cnt"}, 64'(write_cnt), STATS ? 64'(wr) : 64'd0);
        check_eq({tag, "_hit_cnt"},   64'(hit_cnt),   STATS ? 64'(h)  : 64'd0);
        check_eq({tag, "_miss_cnt"},  64'(miss_cnt),  STATS ? 64'(m)  : 64'd0);
    endtask

    function automatic logic [7:0] lru_mask(input cache_line_t [WAYS-1:0] s);
        logic [7:0] mk = '0;
        for (int i = 0; i < WAYS; i++) mk[s[i].lru] = 1'b1;
        return mk;
    endfunction

    int wr_before;

    initial begin
        rst = 1'b1;
        init_load = 1'b1;
        instr_valid = 1'b0;
        instruction = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", 64'(instr_ready), 64'd0);
        check_eq("rst_done",  64'(done), 64'd0);
        check_eq("rst_wr_en", 64'(wr_en), 64'd0);
        check_eq("rst_hit",   64'(hit), 64'd0);
        check_eq("rst_l2",    64'(l2_op), 64'd0);
        chk_cnt("rst", 0, 0, 0, 0);
        rst = 1'b0;
        init_load = 1'b0;
        @(negedge clk);
        check_eq("ready_after_rst", 64'(instr_ready), 64'd1);

        // 1: read miss into an all-invalid set
        issue(4'd0, 12'h012);
        check_eq("t1_lat", 64'(lat), 64'd3);
        check_eq("t1_hit", 64'(r_hit), 64'd0);
        check_eq("t1_way", 64'(r_way), 64'd0);
        check_eq("t1_l2",  64'(r_l2), 64'd1);
        check_eq("t1_wr",  64'(r_wr), 64'd1);
        check_eq("t1_wb",  64'(r_wb), 64'd0);
        check_eq("t1_tag", 64'(r_set[0].tag), 64'h12);
        check_eq("t1_mesi", 64'(r_set[0].mesi), 64'(MESI_E));
        check_eq("t1_lru0", 64'(r_set[0].lru), 64'd0);
        check_eq("t1_lru7", 64'(r_set[7].lru), 64'd7);
        check_eq("t1_data", 64'(r_set[0].data), 64'hD000_0000);
        chk_cnt("t1", 1, 0, 0, 1);

        // 2: write hit on the E line
        issue(4'd1, 12'h012);
        check_eq("t2_hit", 64'(r_hit), 64'd1);
        check_eq("t2_way", 64'(r_way), 64'd0);
        check_eq("t2_mesi", 64'(r_set[0].mesi), 64'(MESI_M));
        check_eq("t2_l2",  64'(r_l2), 64'd0);
        check_eq("t2_wr",  64'(r_wr), 64'd1);
        chk_cnt("t2", 1, 1, 1, 1);

        // 3: fill ways 1..7 with M lines, then evict the LRU way
        for (int k = 1; k < 8; k++) begin
            issue(4'd1, 12'h020 + 12'(k));
            check_eq("t3_fill_way", 64'(r_way), 64'(k));
            check_eq("t3_fill_l2",  64'(r_l2), 64'd2);
            check_eq("t3_fill_wb",  64'(r_wb), 64'd0);
        end
        check_eq("t3_way0_lru", 64'(r_set[0].lru), 64'd7);
        issue(4'd0, 12'h030);
        check_eq("t3_hit", 64'(r_hit), 64'd0);
        check_eq("t3_victim", 64'(r_way), 64'd0);
        check_eq("t3_wb",  64'(r_wb), 64'd1);
        check_eq("t3_l2",  64'(r_l2), 64'd1);
        check_eq("t3_tag", 64'(r_set[0].tag), 64'h30);
        check_eq("t3_mesi", 64'(r_set[0].mesi), 64'(MESI_E));
        check_eq("t3_lru0", 64'(r_set[0].lru), 64'd0);
        check_eq("t3_lru1", 64'(r_set[1].lru), 64'd7);
        check_eq("t3_lru7", 64'(r_set[7].lru), 64'd1);
        check_eq("t3_data", 64'(r_set[0].data), 64'hD000_0000);
        check_eq("t3_perm", 64'(lru_mask(r_set)), 64'hFF);
        chk_cnt("t3", 2, 8, 1, 9);

        // 4: snoops
        issue(4'd4, 12'h027);
        check_eq("t4_sr_hit",  64'(r_hit), 64'd1);
        check_eq("t4_sr_way",  64'(r_way), 64'd7);
        check_eq("t4_sr_mesi", 64'(r_set[7].mesi), 64'(MESI_S));
        check_eq("t4_sr_wb",   64'(r_wb), 64'd1);
        check_eq("t4_sr_lru",  64'(r_set[7].lru), 64'd1);
        check_eq("t4_sr_wr",   64'(r_wr), 64'd1);
        issue(4'd3, 12'h027);
        check_eq("t4_si_mesi", 64'(r_set[7].mesi), 64'(MESI_I));
        check_eq("t4_si_lru",  64'(r_set[7].lru), 64'd1);
        check_eq("t4_si_wb",   64'(r_wb), 64'd0);
        check_eq("t4_si_wr",   64'(r_wr), 64'd1);
        issue(4'd3, 12'h027);
        check_eq("t4_si_miss_hit", 64'(r_hit), 64'd0);
        check_eq("t4_si_miss_wr",  64'(r_wr), 64'd0);
        issue(4'd4, 12'h030);
        check_eq("t4_sr_e_mesi", 64'(r_set[0].mesi), 64'(MESI_S));
        check_eq("t4_sr_e_wb",   64'(r_wb), 64'd0);
        issue(4'd4, 12'h030);
        check_eq("t4_sr_s_wr", 64'(r_wr), 64'd0);
        chk_cnt("t4", 2, 8, 1, 9);

        // Write hit on S needs an RFO
        issue(4'd1, 12'h030);
        check_eq("ws_hit",  64'(r_hit), 64'd1);
        check_eq("ws_mesi", 64'(r_set[0].mesi), 64'(MESI_M));
        check_eq("ws_l2",   64'(r_l2), 64'd2);

        // Read hit on way 2 (LRU 6)
        issue(4'd2, 12'h022);
        check_eq("rh_hit",  64'(r_hit), 64'd1);
        check_eq("rh_way",  64'(r_way), 64'd2);
        check_eq("rh_l2",   64'(r_l2), 64'd0);
        check_eq("rh_lru2", 64'(r_set[2].lru), 64'd0);
        check_eq("rh_lru0", 64'(r_set[0].lru), 64'd1);
        check_eq("rh_lru1", 64'(r_set[1].lru), 64'd7);
        check_eq("rh_lru7", 64'(r_set[7].lru), 64'd2);
        check_eq("rh_mesi", 64'(r_set[2].mesi), 64'(MESI_M));
        check_eq("rh_perm", 64'(lru_mask(r_set)), 64'hFF);
        chk_cnt("rh", 3, 9, 3, 9);

        // No-op and undefined opcodes
        issue(4'd9, 12'h022);
        check_eq("op9_lat", 64'(lat), 64'd1);
        check_eq("op9_wr",  64'(r_wr), 64'd0);
        issue(4'd6, 12'h022);
        check_eq("op6_lat", 64'(lat), 64'd1);
        check_eq("op6_wr",  64'(r_wr), 64'd0);
        chk_cnt("undef", 3, 9, 3, 9);

        // 6: counter clear
        issue(4'd8, 12'h000);
        check_eq("op8_lat", 64'(lat), 64'd1);
        check_eq("op8_wr",  64'(r_wr), 64'd0);
        chk_cnt("op8", 0, 0, 0, 0);

        // 5: reset during EVAL aborts the command
        @(negedge clk);
        instruction.n = 4'd0;
        instruction.address.tag = 12'h022;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        wr_before = wr_cnt;
        rst = 1'b1;
        @(negedge clk);
        check_eq("abort_done",  64'(done), 64'd0);
        check_eq("abort_wr",    64'(wr_en), 64'd0);
        check_eq("abort_ready", 64'(instr_ready), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("abort_ready_after", 64'(instr_ready), 64'd1);
        check_eq("abort_done_after",  64'(done), 64'd0);
        check_eq("abort_no_write",    64'(wr_cnt), 64'(wr_before));

        // Read hit on an MRU way leaves the set unchanged
        issue(4'd0, 12'h022);
        check_eq("mru_hit", 64'(r_hit), 64'd1);
        check_eq("mru_way", 64'(r_way), 64'd2);
        check_eq("mru_wr",  64'(r_wr), 64'd0);
        chk_cnt("mru", 1, 0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
